// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer. Covers load-use hazards, taken branches,
// multi-cycle MDU ops held in EX, and data-memory wait states with a timeout.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memread,
    input  logic        branch_taken,
    input  logic        mdu_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        idex_wen,
    output logic        exmem_wen,
    output logic        memwb_wen,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    localparam int MDU_CW  = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam int WAIT_CW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t             state, next_state;
    logic [MDU_CW-1:0]  mdu_cnt, mdu_cnt_nxt;
    logic [WAIT_CW-1:0] wait_cnt, wait_cnt_nxt;
    logic               load_use;
    logic               do_run, allow_mem, allow_mdu;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (ex_rt == id_rs)) ||
                       (id_uses_rt && (ex_rt == id_rt)));

    assign busy = (state != RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            mdu_cnt      <= '0;
            wait_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            state    <= next_state;
            mdu_cnt  <= mdu_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_wen && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    // Each state either produces its own outputs or defers to the shared RUN
    // priority chain, with the allow_* flags masking the rules it must skip.
    always_comb begin
        next_state   = state;
        mdu_cnt_nxt  = mdu_cnt;
        wait_cnt_nxt = wait_cnt;
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
        idex_wen     = 1'b1;
        exmem_wen    = 1'b1;
        memwb_wen    = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        mem_err      = 1'b0;
        do_run       = 1'b0;
        allow_mem    = 1'b0;
        allow_mdu    = 1'b0;

        unique case (state)
            RUN: begin
                do_run    = 1'b1;
                allow_mem = 1'b1;
                allow_mdu = 1'b1;
            end
            MDU_BUSY: begin
                if (mdu_cnt != '0) begin
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_wen    = 1'b0;
                    exmem_flush = 1'b1;
                    mdu_cnt_nxt = mdu_cnt - 1'b1;
                end else begin
                    do_run     = 1'b1;
                    next_state = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    do_run       = 1'b1;
                    allow_mdu    = 1'b1;
                    next_state   = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_CW'(MEM_TIMEOUT - 1)) begin
                    mem_err      = 1'b1;
                    memwb_flush  = 1'b1;
                    next_state   = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    pc_wen       = 1'b0;
                    ifid_wen     = 1'b0;
                    idex_wen     = 1'b0;
                    exmem_wen    = 1'b0;
                    memwb_wen    = 1'b0;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: next_state = RUN;
        endcase

        if (do_run) begin
            if (allow_mem && mem_req && !mem_ready) begin
                pc_wen       = 1'b0;
                ifid_wen     = 1'b0;
                idex_wen     = 1'b0;
                exmem_wen    = 1'b0;
                memwb_wen    = 1'b0;
                next_state   = MEM_WAIT;
                wait_cnt_nxt = WAIT_CW'(1);
            end else if (allow_mdu && mdu_start) begin
                pc_wen      = 1'b0;
                ifid_wen    = 1'b0;
                idex_wen    = 1'b0;
                exmem_flush = 1'b1;
                mdu_cnt_nxt = MDU_CW'(MDU_LAT - 2);
                next_state  = MDU_BUSY;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_wen     = 1'b0;
                ifid_wen   = 1'b0;
                idex_flush = 1'b1;
            end
        end

        // Hold the whole pipeline quiet while reset is asserted.
        if (!reset_n) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_wen    = 1'b0;
            exmem_wen   = 1'b0;
            memwb_wen   = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            memwb_flush = 1'b0;
            mem_err     = 1'b0;
        end
    end

endmodule
